// File: rtl/instmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instmem_pkg
// Brief   : Instruction-memory geometry and boot-loader state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package instmem_pkg;

  localparam int unsigned MEM_DEPTH  = 1024;
  localparam int unsigned MEM_WIDTH  = 8;
  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/instmem_loader.sv
`default_nettype none
// ============================================================================
// Module  : instmem_loader
// Brief   : Writes a framed boot image into instruction memory and releases
//           the CPU reset once the frame checksum matches.
// Revision: 1.0 - initial release
// ============================================================================
module instmem_loader #(
  parameter int unsigned MEM_DEPTH  = instmem_pkg::MEM_DEPTH,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [7:0]            mem_wr_data,
  output logic                  cpu_nrst,
  output logic                  load_done,
  output logic                  load_err
);
  import instmem_pkg::*;

  loader_state_t         r_state;
  loader_state_t         w_state_next;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_remain;
  logic [7:0]            r_sum;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_accept;
  logic [15:0]           w_len;
  logic                  w_len_bad;
  logic                  w_last;
  logic                  w_csum_ok;

  assign w_accept  = rx_valid && rx_ready;
  assign w_len     = {r_len_hi, rx_data};
  assign w_len_bad = 32'(w_len) > MEM_DEPTH;
  assign w_last    = (r_remain == 16'd1);
  assign w_csum_ok = (rx_data == r_sum);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_LEN_HI;
    end else begin
      r_state <= w_state_next;
    end
  end

  // rx_ready depends on r_state only, never on rx_valid.
  always_comb begin
    w_state_next = r_state;
    rx_ready     = 1'b0;
    case (r_state)
      S_LEN_HI: begin
        rx_ready = 1'b1;
        if (w_accept) w_state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        if (w_accept) begin
          if (w_len_bad)          w_state_next = S_ERR;
          else if (w_len == 16'd0) w_state_next = S_CSUM;
          else                    w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (w_accept && w_last) w_state_next = S_CSUM;
      end
      S_CSUM: begin
        rx_ready = 1'b1;
        if (w_accept) w_state_next = w_csum_ok ? S_DONE : S_ERR;
      end
      S_DONE:  w_state_next = S_DONE;
      S_ERR:   w_state_next = S_ERR;
      default: w_state_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_len_hi    <= 8'd0;
      r_remain    <= 16'd0;
      r_sum       <= 8'd0;
      r_addr      <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= 8'd0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      cpu_nrst    <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_LEN_HI: r_len_hi <= rx_data;
          S_LEN_LO: r_remain <= w_len;
          S_DATA: begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= r_addr;
            mem_wr_data <= rx_data;
            r_sum       <= r_sum + rx_data;
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            r_remain    <= r_remain - 16'd1;
          end
          default: ;
        endcase
      end
      // Terminal states are sticky, so status simply mirrors the next state.
      load_done <= (w_state_next == S_DONE);
      load_err  <= (w_state_next == S_ERR);
      cpu_nrst  <= (w_state_next == S_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instmem_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_instmem_loader
// Brief   : Randomized frame stimulus checked cycle-by-cycle against a
//           frame-position model of the loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instmem_loader;
  import instmem_pkg::*;

  localparam int ADDR_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  nrst = 1'b0;
  logic [7:0]            rx_data = 8'd0;
  logic                  rx_valid = 1'b0;
  logic                  rx_ready;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [7:0]            mem_wr_data;
  logic                  cpu_nrst;
  logic                  load_done;
  logic                  load_err;

  always #5 clk = ~clk;

  instmem_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .cpu_nrst(cpu_nrst), .load_done(load_done),
    .load_err(load_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the frame decides what each accepted byte means.
  int         m_idx, m_len;
  logic [7:0] m_hi, m_sum, m_data;
  bit         m_term, m_done, m_err, m_wr;
  int         m_addr;

  int         n_writes;
  int         last_wr_addr;
  logic [7:0] shadow [0:1023];
  logic [7:0] pay [0:1023];

  task automatic model_reset();
    m_idx = 0; m_len = 0; m_hi = 0; m_sum = 0; m_data = 0;
    m_term = 0; m_done = 0; m_err = 0; m_wr = 0; m_addr = 0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (m_idx == 0) begin
      m_hi = b;
    end else if (m_idx == 1) begin
      m_len = {m_hi, b};
      if (m_len > int'(MEM_DEPTH)) begin m_term = 1; m_err = 1; end
    end else if (m_idx < m_len + 2) begin
      m_wr = 1; m_addr = m_idx - 2; m_data = b; m_sum = m_sum + b;
    end else begin
      m_term = 1;
      if (b == m_sum) m_done = 1; else m_err = 1;
    end
    m_idx++;
  endtask

  always @(negedge clk) begin
    if (!nrst) begin
      model_reset();
      chk("rst_rx_ready", rx_ready, 1);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_wr_addr", mem_wr_addr, 0);
      chk("rst_wr_data", mem_wr_data, 0);
      chk("rst_cpu_nrst", cpu_nrst, 0);
      chk("rst_load_done", load_done, 0);
      chk("rst_load_err", load_err, 0);
    end else begin
      chk("rx_ready", rx_ready, m_term ? 0 : 1);
      chk("wr_en", mem_wr_en, m_wr);
      if (m_wr) begin
        chk("wr_addr", mem_wr_addr, m_addr);
        chk("wr_data", mem_wr_data, m_data);
      end
      chk("load_done", load_done, m_done);
      chk("load_err", load_err, m_err);
      chk("cpu_nrst", cpu_nrst, m_done);
      if (mem_wr_en) begin
        n_writes++;
        last_wr_addr = int'(mem_wr_addr);
        if (mem_wr_addr < 1024) shadow[mem_wr_addr[9:0]] = mem_wr_data;
      end
      m_wr = 0;
      if (rx_valid && !m_term) model_accept(rx_data);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    nrst = 1'b0; rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    n_writes = 0; last_wr_addr = -1;
    for (int i = 0; i < 1024; i++) shadow[i] = 8'hFF;
  endtask

  task automatic send(input logic [7:0] b, input int idle_pct);
    int t;
    rx_valid = 1'b0;
    while ($urandom_range(0, 99) < idle_pct) begin
      rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_data = b; rx_valid = 1'b1; t = 0;
    while (!rx_ready) begin
      @(posedge clk); #1;
      t++;
      if (t >= 16) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0h not accepted within %0d cycles", b, t);
        break;
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit bad, input int idle_pct);
    logic [7:0] s;
    s = 8'd0;
    send(8'(len >> 8), idle_pct);
    send(8'(len), idle_pct);
    for (int i = 0; i < len; i++) begin
      send(pay[i], idle_pct);
      s = s + pay[i];
    end
    send(bad ? s + 8'd1 : s, idle_pct);
    @(posedge clk); #1;
  endtask

  task automatic offer_after(input int cycles);
    rx_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      rx_data = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic load_frame1();
    logic [7:0] f [0:7];
    f = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) pay[i] = f[i];
  endtask

  task automatic chk_frame1_writes(input string tag);
    chk({tag, "_writes"}, n_writes, 8);
    chk({tag, "_mem0"}, shadow[0], 8'h20);
    chk({tag, "_mem1"}, shadow[1], 8'h08);
    chk({tag, "_mem3"}, shadow[3], 8'h05);
    chk({tag, "_mem7"}, shadow[7], 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bit bad;
    do_reset();

    load_frame1();
    send_frame(8, 0, 0);
    chk_frame1_writes("good");
    chk("good_done", load_done, 1);
    chk("good_cpu", cpu_nrst, 1);
    chk("good_err", load_err, 0);
    offer_after(4);
    chk("good_after_writes", n_writes, 8);

    do_reset();
    send_frame(8, 1, 0);
    chk_frame1_writes("badcs");
    chk("badcs_err", load_err, 1);
    chk("badcs_cpu", cpu_nrst, 0);
    chk("badcs_ready", rx_ready, 0);
    offer_after(3);

    do_reset();
    send_frame(0, 0, 0);
    chk("zero_writes", n_writes, 0);
    chk("zero_done", load_done, 1);

    do_reset();
    send_frame(0, 1, 0);
    chk("zero_bad_err", load_err, 1);
    chk("zero_bad_done", load_done, 0);

    do_reset();
    send(8'h04, 0);
    send(8'h01, 0);
    chk("len1025_err", load_err, 1);
    offer_after(5);
    chk("len1025_writes", n_writes, 0);

    do_reset();
    for (int i = 0; i < 1024; i++) pay[i] = 8'($urandom);
    send_frame(1024, 0, 0);
    chk("len1024_writes", n_writes, 1024);
    chk("len1024_last_addr", last_wr_addr, 1023);
    chk("len1024_done", load_done, 1);

    do_reset();
    load_frame1();
    send_frame(8, 0, 50);
    chk_frame1_writes("idle");
    chk("idle_done", load_done, 1);

    do_reset();
    send(8'h00, 0);
    send(8'h08, 0);
    for (int i = 0; i < 3; i++) send(pay[i], 0);
    do_reset();
    send_frame(8, 0, 0);
    chk_frame1_writes("restart");
    chk("restart_done", load_done, 1);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      len = $urandom_range(1, 48);
      bad = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
      send_frame(len, bad, $urandom_range(0, 60));
      chk("rand_writes", n_writes, len);
      chk("rand_done", load_done, !bad);
      chk("rand_err", load_err, bad);
      for (int i = 0; i < len; i++) chk("rand_mem", shadow[i], pay[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instmem_loader.md
# instmem_loader

Boot-time writer for the byte-addressed instruction memory. Accepts a framed byte stream (length header, payload, checksum) on a valid/ready interface and issues one byte write per payload byte into consecutive memory addresses starting at 0, in big-endian order (byte at address a is the MSB of the word at a). It holds the processor in reset until a frame has loaded and passed its checksum. It sits between the host/UART receive path and the instruction memory's write port.

## Interface
- MEM_DEPTH, 1024, instruction memory size in bytes; maximum accepted payload length
- ADDR_WIDTH, 32, width of mem_wr_addr (matches the datapath word width)
- clk  in  1  system clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- rx_data  in  8  incoming stream byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready at a rising edge
- mem_wr_en  out  1  one-cycle byte write strobe
- mem_wr_addr  out  ADDR_WIDTH  byte address of the write
- mem_wr_data  out  8  byte to write
- cpu_nrst  out  1  active-low processor reset; low until a successful load
- load_done  out  1  frame loaded and checksum matched (sticky)
- load_err  out  1  frame rejected (sticky)

## Operation
- Frame format: LEN_HI, LEN_LO (16-bit big-endian payload length N), then N payload bytes, then CSUM, where CSUM = (sum of payload bytes) mod 256.
- States:
  - S_LEN_HI: on accept, latch the high length byte, then go to S_LEN_LO.
  - S_LEN_LO: on accept, form N.
    - N > MEM_DEPTH: go to S_ERR.
    - N == 0: go to S_CSUM.
    - Otherwise: go to S_DATA.
  - S_DATA: on each accept, write the byte at addr_cnt, add it to the 8-bit running sum, increment addr_cnt, and decrement the remaining count. Accepting the last byte moves to S_CSUM.
  - S_CSUM: on accept, compare the byte with the running sum. A match moves to S_DONE; a mismatch moves to S_ERR.
  - S_DONE and S_ERR are terminal. They are left only through nrst.
- rx_ready: 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM; 0 in S_DONE and S_ERR.
- Writes already issued before an error are not undone. cpu_nrst stays low, so the processor never runs a partial image.
- Running sum: 8 bits, wraps modulo 256. Payload counter: 16 bits. addr_cnt: ADDR_WIDTH bits, zero-extended.
- Bytes offered after S_DONE or S_ERR are not accepted, because rx_ready is 0.

## Timing
- Reset values: state = S_LEN_HI, rx_ready = 1, mem_wr_en = 0, mem_wr_addr = 0, mem_wr_data = 0, cpu_nrst = 0, load_done = 0, load_err = 0, sum = 0, addr_cnt = 0.
- Assertion of nrst mid-frame aborts immediately. The next frame restarts at LEN_HI, address 0.
- rx_ready is a function of registered state only. It must not combinationally depend on rx_valid.
- Write latency: mem_wr_en, mem_wr_addr and mem_wr_data are registered. The strobe is high for exactly the cycle after a payload byte is accepted. Back-to-back accepts give back-to-back strobes.
- Throughput: one byte per cycle. rx_valid may drop for any number of cycles with no effect on state.
- Completion: load_done and cpu_nrst rise together, in the cycle after a matching CSUM is accepted.
- Error: load_err rises in the cycle after the offending LEN_LO or CSUM is accepted. cpu_nrst remains 0.
- Length boundaries: N == MEM_DEPTH is legal; its last write goes to address MEM_DEPTH-1. N == MEM_DEPTH+1 is an error.

## Structure
- Shared package instmem_pkg holds:
  - MEM_DEPTH, MEM_WIDTH (8) and WORD_WIDTH (32) constants, shared with the instruction memory.
  - The loader state encoding (S_LEN_HI … S_ERR, 3 bits).
- Single module. No sub-module: the FSM, counters and checksum accumulator are small enough to keep together (roughly 150–250 lines).

## Test plan
- Frame 00 08 | 20 08 00 05 00 00 00 00 | 2D: writes 0x20, 0x08, 0x00, 0x05 to addresses 0–3 and 0x00 to addresses 4–7, eight strobes in total; load_done = 1, cpu_nrst = 1, load_err = 0.
- Same frame with CSUM = 2E: same eight writes occur; load_err = 1, cpu_nrst stays 0, rx_ready = 0 afterwards.
- Frame 00 00 | 00: no write strobes; load_done = 1. Frame 00 00 | 01 instead gives load_err = 1.
- Length 04 01 (1025): load_err = 1 the cycle after LEN_LO is accepted; no writes; subsequent bytes are not accepted.
- 8-byte frame with rx_valid randomly deasserted on about 50% of cycles: identical writes and result to the first case; addresses are strictly sequential with no duplicates.
- nrst pulsed low after 3 payload bytes, then the full 8-byte frame resent: all outputs return to reset values; the second frame writes addresses 0–7 again and ends with load_done = 1.
